// File: rtl/rand_dispatcher_pkg.sv
// Shared types and helpers for the random-number dispatcher.
// Holds the FSM state encoding, the default widths and the rejection-mask helper.
package rand_dispatcher_pkg;

  localparam int RW_DEF = 20;
  localparam int OW_DEF = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Smallest all-ones mask 2^k-1 with 2^k >= lim (lim must be non-zero).
  function automatic logic [31:0] mask_for(input logic [32:0] lim);
    logic [32:0] m;
    logic [31:0] mask;
    m    = lim - 33'd1;
    mask = m[31:0];
    for (int i = 0; i < 5; i++) begin
      mask = mask | (mask >> (1 << i));
    end
    return mask;
  endfunction

endpackage

// File: rtl/rand_dispatcher_rr_arbiter.sv
// Round-robin picker: one-hot selection of the first asserted request at or
// after ptr, wrapping around.
module rand_dispatcher_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  logic [PW-1:0] cand_s;
  logic          found_s;

  // Scan from ptr upward, taking the first requester found.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = PW'((int'(ptr) + off) % NREQ);
      if (!found_s && req[cand_s]) begin
        pick[cand_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rand_dispatcher.sv
// Shares the prng word stream among game requesters: round-robin grant, one
// draw per full LFSR refresh, rejection sampling into [0, limit).
module rand_dispatcher
  import rand_dispatcher_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int RW     = RW_DEF,
  parameter int OW     = OW_DEF,
  parameter int STRIDE = 20,
  parameter int MAXTRY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               prng_seed,
  input  logic [RW-1:0]      prng_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*OW-1:0] limit,
  output logic [NREQ-1:0]    gnt,
  output logic [OW-1:0]      rnd,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int TW = (MAXTRY > 1) ? $clog2(MAXTRY) : 1;
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);
  localparam logic [TW-1:0] TRY_LAST    = TW'(MAXTRY - 1);
  localparam logic [PW-1:0] PTR_LAST    = PW'(NREQ - 1);

  state_e          state_q, state_d;
  logic            prng_seed_q, prng_seed_d;
  logic [SW-1:0]   stride_q, stride_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   try_q, try_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [OW:0]     lim_q, lim_d;
  logic [OW-1:0]   mask_q, mask_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   rnd_q, rnd_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pick_s;
  logic            any_s;
  logic [PW-1:0]   pick_idx_s;
  logic [OW-1:0]   lim_raw_s;
  logic [OW:0]     lim_sel_s;
  logic [OW-1:0]   c_s;
  logic            accept_s;
  logic [OW-1:0]   fallback_s;
  logic [NREQ-1:0] grant_vec_s;
  logic            tick_s;
  logic            unused_prng_hi_s;

  rand_dispatcher_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (req),
    .ptr  (rr_ptr_q),
    .pick (pick_s),
    .any  (any_s)
  );

  // Only the low OW bits of the LFSR word feed the draw.
  assign unused_prng_hi_s = ^prng_n[RW-1:OW];

  // Encode the one-hot pick and fetch that requester's range (0 means 2^OW).
  always_comb begin
    pick_idx_s = '0;
    lim_raw_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s[i]) begin
        pick_idx_s = PW'(i);
        lim_raw_s  = limit[i*OW +: OW];
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
    if (lim_raw_s == '0) begin
      lim_sel_s = {1'b1, {OW{1'b0}}};
    end else begin
      lim_sel_s = {1'b0, lim_raw_s};
    end
  end

  // Candidate from the current word; since c < 2*lim, c - lim is always in range.
  always_comb begin
    tick_s      = (stride_q == STRIDE_LAST);
    c_s         = prng_n[OW-1:0] & mask_q;
    accept_s    = ({1'b0, c_s} < lim_q);
    fallback_s  = OW'({1'b0, c_s} - lim_q);
    grant_vec_s = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
  end

  // Next-state logic for the dispatcher FSM and its side registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lim_d       = lim_q;
    mask_d      = mask_q;
    rr_ptr_d    = rr_ptr_q;
    try_d       = try_q;
    rnd_d       = rnd_q;
    gnt_d       = '0;
    prng_seed_d = prng_seed_q | start;
    if (tick_s) begin
      stride_d = '0;
    end else begin
      stride_d = stride_q + SW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          idx_d   = pick_idx_s;
          lim_d   = lim_sel_s;
          mask_d  = OW'(mask_for(33'(lim_sel_s)));
          try_d   = '0;
          state_d = ST_WAIT;
          if (pick_idx_s == PTR_LAST) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = pick_idx_s + PW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A requester that withdraws forfeits the draw without a grant.
        if (!req[idx_q]) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          if (accept_s) begin
            rnd_d   = c_s;
            gnt_d   = grant_vec_s;
            state_d = ST_IDLE;
          end else if (try_q < TRY_LAST) begin
            try_d = try_q + TW'(1);
          end else begin
            rnd_d   = fallback_s;
            gnt_d   = grant_vec_s;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_WAIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prng_seed_q <= 1'b0;
      stride_q    <= '0;
      rr_ptr_q    <= '0;
      try_q       <= '0;
      idx_q       <= '0;
      lim_q       <= '0;
      mask_q      <= '0;
      gnt_q       <= '0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prng_seed_q <= prng_seed_d;
      stride_q    <= stride_d;
      rr_ptr_q    <= rr_ptr_d;
      try_q       <= try_d;
      idx_q       <= idx_d;
      lim_q       <= lim_d;
      mask_q      <= mask_d;
      gnt_q       <= gnt_d;
      rnd_q       <= rnd_d;
      busy_q      <= busy_d;
    end
  end

  assign prng_seed = prng_seed_q;
  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign busy      = busy_q;

endmodule
